burst_rr_arbiter: RTL
=====================

// Module: burst_rr_arbiter
// PURPOSE
//  N-way registered arbiter for shared-resource access with a per-holder burst limit.
//  The current holder keeps the grant for up to MAX_BURST consecutive cycles, then
//  yields round-robin to the next requester.
//  Generalises the two-requester fixed-limit arbiter to N channels with fair rotation.
//  Sits between N requesting masters and a single shared resource.
// PARAMETERS
//  N          4   number of requesters, >= 2
//  MAX_BURST  5   max consecutive grant cycles to one holder when others are waiting, >= 1
//  CNT_W      3   burst counter width, must hold MAX_BURST
//  IDX_W (localparam) = $clog2(N)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous active-high reset
//  req          in   N      per-requester request, level-sensitive
//  grant        out  N      one-hot grant (all-zero when idle), registered
//  grant_valid  out  1      |grant, registered
//  grant_idx    out  IDX_W  index of granted requester; 0 when idle
//  burst_cnt    out  CNT_W  consecutive cycles current holder has held grant; 0 when idle
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - grant = 0, grant_valid = 0, grant_idx = 0, burst_cnt = 0.
//    - Internal last-grant pointer ptr = N-1, so the first search starts at index 0.
//  - Latency: one cycle. Outputs after edge k depend only on req sampled at edge k and
//    on the state before it. No combinational path from req to grant.
//  - States:
//    - IDLE (grant == 0).
//    - HOLD(h): one-hot grant to h, burst_cnt in 1..MAX_BURST.
//  - Search(s): first index i with req[i] = 1, scanning s, s+1, ... with wrap mod N.
//    Returns none if req == 0.
//  - Each edge, in priority order:
//    1. HOLD(h), req[h] = 1, burst_cnt < MAX_BURST: keep h; burst_cnt += 1.
//    2. HOLD(h), req[h] = 1, burst_cnt == MAX_BURST:
//       - Search(h+1) over req with bit h masked.
//       - If found j: grant j, burst_cnt = 1, ptr = j.
//       - Otherwise keep h with burst_cnt saturated at MAX_BURST. A lone requester is
//         never dropped.
//    3. HOLD(h) with req[h] = 0, or IDLE:
//       - j = Search(ptr+1).
//       - If found: grant j, burst_cnt = 1, ptr = j.
//       - Otherwise go to IDLE, burst_cnt = 0, ptr unchanged.
//  - A holder dropping req loses the grant at the next edge. There is no dead cycle when
//    another requester is pending.
//  - Fairness: with every requester continuously active, each is granted exactly MAX_BURST
//    cycles per rotation, in index order with wrap.
//  - Invariants:
//    - grant is always one-hot or zero.
//    - grant_idx matches grant.
//    - burst_cnt never exceeds MAX_BURST and never wraps.
//  - Reset mid-burst clears grant immediately, without waiting for a clock edge. After
//    release, arbitration restarts from index 0.
//  - req bits of non-holders may toggle freely. Only their value at the sampling edge matters.
// TESTING (N=4, MAX_BURST=3)
//  1. Reset with req=4'b1111 held -> all outputs 0 while reset high. First edge after
//     release: grant=0001, grant_idx=0, burst_cnt=1.
//  2. req=0001 constant -> grant=0001 every cycle. burst_cnt goes 1,2,3,3,3...
//     (lone holder kept, counter saturates).
//  3. req=0011 constant from idle -> grant 0001 x3, 0010 x3, 0001 x3, ...
//     burst_cnt cycles 1,2,3.
//  4. req=1111 constant -> 0001 x3, 0010 x3, 0100 x3, 1000 x3, 0001 x3
//     (wrap covered).
//  5. Holder 0100 at burst_cnt=1, req changes to 1001 -> next grant=1000 (search from
//     index 3), burst_cnt=1. Then req=0000 -> grant=0, grant_valid=0, burst_cnt=0.
//  6. Async reset pulse between edges while grant=0010 -> grant=0 before the next edge.
//     After release with req=0100 -> grant=0100.

Source files
------------

// File: rtl/burst_rr_arbiter.sv
// N-way round-robin arbiter with a per-holder burst limit. All outputs are registered.
// A holder keeps the grant for up to MAX_BURST cycles while others wait, then yields to the next requester.
module burst_rr_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 5,
  parameter int CNT_W     = 3,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [CNT_W-1:0] burst_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Returns {found, index} for the first set bit of r, scanning s, s+1, ... mod N.
  function automatic logic [IDX_W:0] rr_search(input logic [N-1:0] r, input int s);
    logic [IDX_W:0] res;
    int             i;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      i = (s + k) % N;
      if (r[i]) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  logic             holder_req;
  logic             at_limit;
  logic [N-1:0]     others_req;
  logic [IDX_W:0]   yield_res;
  logic [IDX_W:0]   fresh_res;

  always_comb begin
    holder_req = (state_q == HOLD) && req[idx_q];
    at_limit   = (cnt_q >= CNT_W'(MAX_BURST));
    others_req = req & ~(N'(1) << idx_q);
    yield_res  = rr_search(others_req, int'(idx_q) + 1);
    fresh_res  = rr_search(req, int'(ptr_q) + 1);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (holder_req && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (holder_req) begin
      if (yield_res[IDX_W]) begin
        state_d = HOLD;
        idx_d   = yield_res[IDX_W-1:0];
        grant_d = N'(1) << yield_res[IDX_W-1:0];
        cnt_d   = CNT_W'(1);
        ptr_d   = yield_res[IDX_W-1:0];
      end else begin
        // Lone requester at the limit keeps the grant; the counter stays saturated.
        cnt_d = CNT_W'(MAX_BURST);
      end
    end else if (fresh_res[IDX_W]) begin
      state_d = HOLD;
      idx_d   = fresh_res[IDX_W-1:0];
      grant_d = N'(1) << fresh_res[IDX_W-1:0];
      cnt_d   = CNT_W'(1);
      ptr_d   = fresh_res[IDX_W-1:0];
    end else begin
      state_d = IDLE;
      idx_d   = '0;
      grant_d = '0;
      cnt_d   = '0;
    end
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign burst_cnt   = cnt_q;

  a_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_cnt_max : assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_W'(MAX_BURST));
  a_valid : assert property (@(posedge clk) disable iff (reset) valid_q == (|grant_q));

endmodule
